// File: rtl/line_tracker_pkg.sv
// line_tracker_pkg
// Shared types for the line tracker: steering mode encoding, side memory
// and the width helper for the signed line-position error.
// No ports (package).
package line_tracker_pkg;

  typedef enum logic [2:0] {
    STRAIGHT = 3'd0,
    TURN_L   = 3'd1,
    TURN_R   = 3'd2,
    SHARP_L  = 3'd3,
    SHARP_R  = 3'd4,
    SEARCH_L = 3'd5,
    SEARCH_R = 3'd6,
    STOP     = 3'd7
  } mode_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  // Signed width able to hold +/-(n-1).
  function automatic int err_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/line_tracker_fsm_if.sv
// line_tracker_fsm_if
// Bundles the raw sensor pins and the steering outputs of the tracker.
//   sensor_n  : raw active-low sensors (0 = line), index N-1 leftmost
//   mode      : steering mode (mode_t)
//   err       : signed line-position error, positive = line to the left
//   line_lost : high in SEARCH_L / SEARCH_R / STOP
//   mode_chg  : one-cycle pulse when mode takes a new value
// Modports: master drives the sensors and observes the outputs,
//           slave is the tracker itself.
interface line_tracker_fsm_if #(
  parameter int N_SENSORS = 5
);
  import line_tracker_pkg::*;

  logic [N_SENSORS-1:0]              sensor_n;
  mode_t                             mode;
  logic signed [err_w(N_SENSORS)-1:0] err;
  logic                              line_lost;
  logic                              mode_chg;

  modport master (
    output sensor_n,
    input  mode, err, line_lost, mode_chg
  );

  modport slave (
    input  sensor_n,
    output mode, err, line_lost, mode_chg
  );

endinterface

// File: rtl/sensor_debounce.sv
// sensor_debounce
// One sensor channel: 2-FF synchroniser followed by a debounce counter.
// The filtered bit only follows the synchronised value after it has
// disagreed with the filtered bit for DEBOUNCE+1 consecutive samples;
// any agreeing sample restarts the count, so short excursions vanish.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   raw_n      : asynchronous raw sensor bit
//   filt       : filtered sensor bit (resets to 1 = white)
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic filt
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          filt_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      filt_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE)) begin
        // Counter already saw DEBOUNCE disagreeing samples; this is one more.
        filt_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/line_tracker_fsm.sv
// line_tracker_fsm
// N-channel line tracking controller. Debounces the sensors, derives the
// signed line-position error from the outermost detecting sensors,
// classifies it into a steering mode and runs the lost-line recovery.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : line_tracker_fsm_if.slave (sensor_n in; mode, err,
//           line_lost, mode_chg out, all registered)
// Build option: define LINE_SEARCH_EN to search toward the last seen side
// for SEARCH_TIMEOUT cycles before stopping; otherwise a lost line goes
// straight to STOP after LOST_TIMEOUT cycles.
module line_tracker_fsm #(
  parameter int N_SENSORS      = 5,
  parameter int DEBOUNCE       = 4,
  parameter int STRAIGHT_BAND  = 0,
  parameter int SHARP_TH       = 3,
  parameter int LOST_TIMEOUT   = 100,
  parameter int SEARCH_TIMEOUT = 200
) (
  input logic               clk,
  input logic               reset,
  line_tracker_fsm_if.slave bus
);
  import line_tracker_pkg::*;

  localparam int ERR_W = err_w(N_SENSORS);
  localparam int CNT_W = $clog2(LOST_TIMEOUT + SEARCH_TIMEOUT + 1);
`ifdef LINE_SEARCH_EN
  localparam int CNT_SAT = LOST_TIMEOUT + SEARCH_TIMEOUT;
`else
  localparam int CNT_SAT = LOST_TIMEOUT;
`endif

  logic [N_SENSORS-1:0] filt;
  logic [N_SENSORS-1:0] det;

  generate
    for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_chan
      sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw_n (bus.sensor_n[gi]),
        .filt  (filt[gi])
      );
    end
  endgenerate

  assign det = ~filt;

  // Leftmost (highest) and rightmost (lowest) detecting sensor.
  int l_idx;
  int r_idx;
  always_comb begin
    l_idx = 0;
    r_idx = 0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (det[i]) l_idx = i;
    end
    for (int i = N_SENSORS - 1; i >= 0; i--) begin
      if (det[i]) r_idx = i;
    end
  end

  mode_t                   mode_reg, mode_next;
  logic signed [ERR_W-1:0] err_reg, err_next;
  logic                    line_lost_reg, line_lost_next;
  logic                    mode_chg_reg, mode_chg_next;
  logic [CNT_W-1:0]        lost_cnt_reg, lost_cnt_next;
  side_t                   last_side_reg, last_side_next;
  int                      err_i;
  int                      abs_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg      <= STRAIGHT;
      err_reg       <= '0;
      line_lost_reg <= 1'b0;
      mode_chg_reg  <= 1'b0;
      lost_cnt_reg  <= '0;
      last_side_reg <= LEFT;
    end else begin
      mode_reg      <= mode_next;
      err_reg       <= err_next;
      line_lost_reg <= line_lost_next;
      mode_chg_reg  <= mode_chg_next;
      lost_cnt_reg  <= lost_cnt_next;
      last_side_reg <= last_side_next;
    end
  end

  always_comb begin
    mode_next      = mode_reg;
    err_next       = err_reg;
    lost_cnt_next  = lost_cnt_reg;
    last_side_next = last_side_reg;
    err_i          = l_idx + r_idx - (N_SENSORS - 1);
    abs_i          = (err_i < 0) ? -err_i : err_i;

    if (det != '0) begin
      // Line visible: classify; this also wins over any timeout this cycle.
      lost_cnt_next = '0;
      err_next      = ERR_W'(err_i);
      if (err_i > 0)      last_side_next = LEFT;
      else if (err_i < 0) last_side_next = RIGHT;

      if ((&det) || (abs_i <= STRAIGHT_BAND)) mode_next = STRAIGHT;
      else if (abs_i >= SHARP_TH)             mode_next = (err_i > 0) ? SHARP_L : SHARP_R;
      else                                    mode_next = (err_i > 0) ? TURN_L : TURN_R;
    end else begin
      // No line: count this cycle; mode reacts once the count reaches a
      // threshold, so recovery lands on the edge ending the threshold cycle.
      if (lost_cnt_reg != CNT_W'(CNT_SAT)) lost_cnt_next = lost_cnt_reg + CNT_W'(1);
`ifdef LINE_SEARCH_EN
      if (lost_cnt_next == CNT_W'(CNT_SAT))
        mode_next = STOP;
      else if (lost_cnt_next >= CNT_W'(LOST_TIMEOUT))
        mode_next = (last_side_reg == LEFT) ? SEARCH_L : SEARCH_R;
`else
      if (lost_cnt_next == CNT_W'(CNT_SAT))
        mode_next = STOP;
`endif
    end

    line_lost_next = (mode_next == SEARCH_L) || (mode_next == SEARCH_R) || (mode_next == STOP);
    mode_chg_next  = (mode_next != mode_reg);
  end

  assign bus.mode      = mode_reg;
  assign bus.err       = err_reg;
  assign bus.line_lost = line_lost_reg;
  assign bus.mode_chg  = mode_chg_reg;

endmodule

// File: tb/tb_line_tracker_fsm.sv
module tb_line_tracker_fsm;

  localparam int N     = 5;
  localparam int DEB   = 4;
  localparam int BAND  = 0;
  localparam int SHARP = 3;
  localparam int LOST  = 100;
  localparam int SRCH  = 200;
`ifdef LINE_SEARCH_EN
  localparam bit SEARCH_EN = 1'b1;
`else
  localparam bit SEARCH_EN = 1'b0;
`endif
  localparam int M_SL = SEARCH_EN ? 5 : 7;
  localparam int M_SR = SEARCH_EN ? 6 : 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  line_tracker_fsm_if #(.N_SENSORS(N)) bus ();

  line_tracker_fsm #(
    .N_SENSORS      (N),
    .DEBOUNCE       (DEB),
    .STRAIGHT_BAND  (BAND),
    .SHARP_TH       (SHARP),
    .LOST_TIMEOUT   (LOST),
    .SEARCH_TIMEOUT (SRCH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [N-1:0] hist[$];   // raw samples, oldest first; last entry = previous edge
  logic [N-1:0] m_f;
  int m_mode, m_err, m_run;
  bit m_lost, m_chg, m_left, m_valid = 1'b0;

  task automatic model_step();
    logic [N-1:0] d;
    int l, r, e, a, nm;
    bit flip;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back('1);
      m_f = '1; m_mode = 0; m_err = 0; m_run = 0;
      m_lost = 0; m_chg = 0; m_left = 1; m_valid = 1;
      return;
    end
    d  = ~m_f;
    nm = m_mode;
    if (d != 0) begin
      m_run = 0;
      l = -1; r = -1;
      for (int i = 0; i < N; i++) if (d[i]) begin if (r < 0) r = i; l = i; end
      e = l + r - (N - 1);
      a = (e < 0) ? -e : e;
      m_err = e;
      if (e > 0) m_left = 1; else if (e < 0) m_left = 0;
      if (d == '1 || a <= BAND) nm = 0;
      else if (a >= SHARP)      nm = (e > 0) ? 3 : 4;
      else                      nm = (e > 0) ? 1 : 2;
    end else begin
      m_run++;
      if (SEARCH_EN && m_run >= LOST + SRCH) nm = 7;
      else if (m_run >= LOST)                nm = SEARCH_EN ? (m_left ? 5 : 6) : 7;
    end
    m_chg  = (nm != m_mode);
    m_mode = nm;
    m_lost = (nm >= 5);
    // A channel flips once DEB+1 consecutive samples, ending two edges ago,
    // all disagree with it.
    for (int i = 0; i < N; i++) begin
      flip = 1;
      for (int j = 0; j <= DEB; j++) if (hist[j][i] == m_f[i]) flip = 0;
      if (flip) m_f[i] = ~m_f[i];
    end
    hist.push_back(bus.sensor_n);
    void'(hist.pop_front());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (m_valid) begin
        chk("mdl_mode", int'(bus.mode), m_mode);
        chk("mdl_err", int'(bus.err), m_err);
        chk("mdl_lost", int'(bus.line_lost), int'(m_lost));
        chk("mdl_chg", int'(bus.mode_chg), int'(m_chg));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [N-1:0] cls_pat [4] = '{5'b10011, 5'b01111, 5'b11110, 5'b00000};
  int           cls_err [4] = '{1, 4, -4, 0};
  int           cls_mode[4] = '{1, 3, 4, 0};

  initial begin
    int chg_seen, sel, hold;
    reset = 1'b1;
    bus.sensor_n = '1;
    tick(3);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_lost", int'(bus.line_lost), 0);
    chk("rst_chg", int'(bus.mode_chg), 0);
    reset = 1'b0;

    // Debounce and latency
    bus.sensor_n = 5'b11011; tick(12);
    chk("center_err", int'(bus.err), 0);
    chk("center_mode", int'(bus.mode), 0);
    bus.sensor_n = 5'b10111; tick(7);
    chk("lat_early_mode", int'(bus.mode), 0);
    tick(1);
    chk("lat_mode", int'(bus.mode), 1);
    chk("lat_err", int'(bus.err), 2);
    chk("lat_chg", int'(bus.mode_chg), 1);
    tick(1);
    chk("lat_chg_end", int'(bus.mode_chg), 0);

    // Glitch rejection
    bus.sensor_n = 5'b11011; tick(10);
    chg_seen = 0;
    bus.sensor_n = 5'b01111; tick(3);
    bus.sensor_n = 5'b11011;
    for (int i = 0; i < 15; i++) begin tick(1); if (bus.mode_chg) chg_seen++; end
    chk("glitch_chg", chg_seen, 0);
    chk("glitch_mode", int'(bus.mode), 0);

    // Classification
    for (int i = 0; i < 4; i++) begin
      bus.sensor_n = cls_pat[i]; tick(10);
      chk("cls_err", int'(bus.err), cls_err[i]);
      chk("cls_mode", int'(bus.mode), cls_mode[i]);
    end

    // Lost line toward the left
    bus.sensor_n = 5'b01111; tick(10);
    bus.sensor_n = 5'b11111; tick(106);
    chk("lost_hold_mode", int'(bus.mode), 3);
    chk("lost_hold_flag", int'(bus.line_lost), 0);
    chk("lost_hold_err", int'(bus.err), 4);
    tick(1);
    chk("lost_search_mode", int'(bus.mode), M_SL);
    chk("lost_search_flag", int'(bus.line_lost), 1);
    tick(199);
    chk("search_end_mode", int'(bus.mode), M_SL);
    tick(1);
    chk("stop_mode", int'(bus.mode), 7);
    tick(5);
    bus.sensor_n = 5'b11011; tick(7);
    chk("reacq_early", int'(bus.mode), 7);
    tick(1);
    chk("reacq_mode", int'(bus.mode), 0);
    chk("reacq_flag", int'(bus.line_lost), 0);

    // Side memory toward the right
    bus.sensor_n = 5'b11101; tick(10);
    chk("right_mode", int'(bus.mode), 2);
    chk("right_err", int'(bus.err), -2);
    bus.sensor_n = 5'b11111; tick(107);
    chk("right_search", int'(bus.mode), M_SR);
    chk("right_flag", int'(bus.line_lost), 1);

    // Reset in the middle of a search
    bus.sensor_n = 5'b01111; tick(10);
    bus.sensor_n = 5'b11111; tick(120);
    chk("pre_rst_mode", int'(bus.mode), M_SL);
    reset = 1'b1; tick(1);
    chk("mid_rst_mode", int'(bus.mode), 0);
    chk("mid_rst_err", int'(bus.err), 0);
    chk("mid_rst_flag", int'(bus.line_lost), 0);
    reset = 1'b0; tick(99);
    chk("grace_mode", int'(bus.mode), 0);
    tick(1);
    chk("grace_end_mode", int'(bus.mode), M_SL);

    // Random traffic against the model
    for (int s = 0; s < 400; s++) begin
      sel = $urandom_range(0, 99);
      if (sel < 3) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end else if (sel < 12) begin
        bus.sensor_n = '1;
        hold = $urandom_range(90, 320);
        tick(hold);
      end else begin
        bus.sensor_n = N'($urandom_range(0, 31));
        hold = $urandom_range(1, 12);
        tick(hold);
      end
    end

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
